frame_bank_ctrl: RTL and testbench

FRAME_BANK_CTRL -- requirements
Module: frame_bank_ctrl

---
 rtl/frame_bank_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_frame_bank_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_ctrl.sv
// Triple/double-buffered frame store: one writer fills a bank while the
// reader holds another; completed frames are handed over on request.
module frame_bank_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 17,
  parameter int FRAME_PIX = 130560,
  parameter int NUM_BANKS = 3,
  parameter int OUT_MODE  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_frame_req,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [23:0]       o_rd_data,
  output logic              o_rd_valid,
  output logic              o_rd_ack,
  output logic              o_rd_new,
  output logic              o_frame_ready,
  output logic [1:0]        o_wr_bank,
  output logic [1:0]        o_rd_bank,
  output logic [15:0]       o_drop_cnt,
  output logic              o_wr_err
);

  localparam int CW = $clog2(FRAME_PIX + 1);
  localparam int MW = $clog2(NUM_BANKS * FRAME_PIX);
  localparam logic [CW-1:0] FP_C = CW'(FRAME_PIX);
  localparam logic [ADDR_W:0] FP_A = (ADDR_W + 1)'(FRAME_PIX);
  localparam logic [1:0] RD_RST = 2'(NUM_BANKS - 1);

  typedef enum logic {W_IDLE, W_FILL} wst_e;

  wst_e st_q, st_d;
  logic [1:0] wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0] rd_bank_q, rd_bank_d;
  logic rd_valid_q, rd_valid_d;
  logic pend_v_q, pend_v_d;
  logic [1:0] pend_b_q, pend_b_d;
  logic [15:0] drop_q, drop_d;
  logic ack_q, ack_d;
  logic new_q, new_d;
  logic err_q, err_d;

  logic s1_v_q, s1_oob_q;
  logic rv_q;
  logic [23:0] rdata_q;
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] mem [NUM_BANKS*FRAME_PIX];

  logic publish;
  logic [1:0] drops;
  logic [2:0] nb;
  logic [16:0] drop_sum;
  logic wr_act, wr_rng, rd_rng, mem_we;
  logic [MW-1:0] mem_wa, mem_ra;
  logic [15:0] p16;
  logic [23:0] pix24;

  // Returns {1'b1, 2'b0} when every bank is taken.
  function automatic logic [2:0] free_bank(input logic [1:0] r,
                                           input logic [1:0] p);
    free_bank = 3'b100;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (2'(b) != r && 2'(b) != p) free_bank = {1'b0, 2'(b)};
    end
  endfunction

  function automatic logic [MW-1:0] flat(input logic [1:0] b,
                                         input logic [ADDR_W-1:0] a);
    flat = MW'(b) * MW'(FRAME_PIX) + MW'(a);
  endfunction

  assign wr_rng = {1'b0, i_wr_addr} < FP_A;
  assign rd_rng = {1'b0, i_rd_addr} < FP_A;
  assign wr_act = (st_q == W_FILL) | i_frame_start;

  always_comb begin
    st_d       = st_q;
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    rd_bank_d  = rd_bank_q;
    rd_valid_d = rd_valid_q;
    pend_v_d   = pend_v_q;
    pend_b_d   = pend_b_q;
    ack_d      = i_rd_frame_req;
    new_d      = 1'b0;
    err_d      = wr_act & i_wr_en & ~wr_rng;
    publish    = 1'b0;
    drops      = 2'd0;
    nb         = 3'b100;
    mem_we     = 1'b0;

    unique case (st_q)
      W_IDLE: begin
        if (i_frame_start) begin
          st_d      = W_FILL;
          wr_bank_d = 2'd0;
          wr_cnt_d  = '0;
        end
      end
      W_FILL: begin
        if (i_frame_start) begin
          wr_cnt_d = '0;
          if (wr_cnt_q == FP_C) begin
            if (pend_v_q) drops = drops + 2'd1;
            pend_v_d = 1'b1;
            pend_b_d = wr_bank_q;
            publish  = 1'b1;
          end else begin
            drops = drops + 2'd1;
          end
        end
      end
    endcase

    // Reader sees a frame published in this very cycle.
    if (i_rd_frame_req && pend_v_d) begin
      rd_bank_d  = pend_b_d;
      pend_v_d   = 1'b0;
      rd_valid_d = 1'b1;
      new_d      = 1'b1;
    end

    if (publish) begin
      nb = free_bank(rd_bank_d, pend_b_d);
      if (nb[2]) begin
        pend_v_d = 1'b0;
        drops    = drops + 2'd1;
      end else begin
        wr_bank_d = nb[1:0];
      end
    end

    if (wr_act && i_wr_en && wr_rng) begin
      mem_we = 1'b1;
      if (wr_cnt_d != FP_C) wr_cnt_d = wr_cnt_d + 1'b1;
    end

    drop_sum = {1'b0, drop_q} + 17'(drops);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign mem_wa = wr_rng ? flat(wr_bank_d, i_wr_addr) : '0;
  assign mem_ra = rd_rng ? flat(rd_bank_q, i_rd_addr) : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q       <= W_IDLE;
      wr_bank_q  <= 2'd0;
      wr_cnt_q   <= '0;
      rd_bank_q  <= RD_RST;
      rd_valid_q <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_b_q   <= 2'd0;
      drop_q     <= 16'd0;
      ack_q      <= 1'b0;
      new_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_valid_d;
      pend_v_q   <= pend_v_d;
      pend_b_q   <= pend_b_d;
      drop_q     <= drop_d;
      ack_q      <= ack_d;
      new_q      <= new_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_wa] <= i_wr_data;
    if (i_rd_en) mem_q <= mem[mem_ra];
  end

  always_comb begin
    p16 = 16'(mem_q);
    if (OUT_MODE == 1) begin
      pix24 = {p16[15:11], p16[15:13], p16[10:5],
               p16[10:9], p16[4:0], p16[4:2]};
    end else begin
      pix24 = 24'(mem_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v_q   <= 1'b0;
      s1_oob_q <= 1'b0;
      rv_q     <= 1'b0;
      rdata_q  <= 24'd0;
    end else begin
      s1_v_q   <= i_rd_en & rd_valid_q;
      s1_oob_q <= ~rd_rng;
      rv_q     <= s1_v_q;
      rdata_q  <= (s1_v_q && !s1_oob_q) ? pix24 : 24'd0;
    end
  end

  assign o_rd_data     = rdata_q;
  assign o_rd_valid    = rv_q;
  assign o_rd_ack      = ack_q;
  assign o_rd_new      = new_q;
  assign o_frame_ready = pend_v_q;
  assign o_wr_bank     = wr_bank_q;
  assign o_rd_bank     = rd_bank_q;
  assign o_drop_cnt    = drop_q;
  assign o_wr_err      = err_q;

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Directed bench for frame_bank_ctrl: 3-bank main instance plus a
// 2-bank instance sharing the same stimulus.
module tb_frame_bank_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic fs = 1'b0, wr_en = 1'b0, req = 1'b0, rd_en = 1'b0;
  logic [16:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;

  logic [23:0] rd_data, rd_data2;
  logic rd_valid, ack, rnew, ready, wr_err;
  logic rd_valid2, ack2, rnew2, ready2, wr_err2;
  logic [1:0] wr_bank, rd_bank, wr_bank2, rd_bank2;
  logic [15:0] drop, drop2;

  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  frame_bank_ctrl #(
    .DATA_W(16), .ADDR_W(17), .FRAME_PIX(16),
    .NUM_BANKS(3), .OUT_MODE(1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_frame_req(req), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rd_ack(ack),
    .o_rd_new(rnew), .o_frame_ready(ready), .o_wr_bank(wr_bank),
    .o_rd_bank(rd_bank), .o_drop_cnt(drop), .o_wr_err(wr_err)
  );

  frame_bank_ctrl #(
    .DATA_W(16), .ADDR_W(17), .FRAME_PIX(16),
    .NUM_BANKS(2), .OUT_MODE(1)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_frame_req(req), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data2), .o_rd_valid(rd_valid2), .o_rd_ack(ack2),
    .o_rd_new(rnew2), .o_frame_ready(ready2), .o_wr_bank(wr_bank2),
    .o_rd_bank(rd_bank2), .o_drop_cnt(drop2), .o_wr_err(wr_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = 17'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    tick();
    fs = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic rd(input int a);
    rd_en = 1'b1;
    rd_addr = 17'(a);
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_data", 32'(rd_data), 32'h0);
    chk("rst_rv", 32'(rd_valid), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_new", 32'(rnew), 32'h0);
    chk("rst_rdy", 32'(ready), 32'h0);
    chk("rst_wb", 32'(wr_bank), 32'h0);
    chk("rst_rb", 32'(rd_bank), 32'h2);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_err", 32'(wr_err), 32'h0);
    chk("rst_rb2", 32'(rd_bank2), 32'h1);
    rst_n = 1'b1;
    tick();

    // no frame latched yet: read must not be valid
    rd(3);
    tick();
    chk("rv_nofrm", 32'(rd_valid), 32'h0);

    // frame 1 into bank 0
    pulse_fs();
    for (int i = 0; i < 16; i++) wr(i, 16'hF800);
    pulse_fs();
    chk("f1_rdy", 32'(ready), 32'h1);
    chk("f1_wb", 32'(wr_bank), 32'h1);
    chk("f1_drop", 32'(drop), 32'h0);
    chk("nb2_wb", 32'(wr_bank2), 32'h0);
    chk("nb2_rdy", 32'(ready2), 32'h0);
    chk("nb2_drop", 32'(drop2), 32'h1);
    pulse_req();
    chk("f1_ack", 32'(ack), 32'h1);
    chk("f1_new", 32'(rnew), 32'h1);
    chk("f1_rb", 32'(rd_bank), 32'h0);
    chk("f1_rdy0", 32'(ready), 32'h0);
    tick();
    chk("ack_pls", 32'(ack), 32'h0);
    rd(5);
    chk("rd5_lat1", 32'(rd_valid), 32'h0);
    tick();
    chk("rd5_v", 32'(rd_valid), 32'h1);
    chk("rd5_d", 32'(rd_data), 32'hFF0000);

    // frame 2 (bank 1): out-of-range write plus 15 good pixels
    wr(16, 16'h1234);
    chk("err_pls", 32'(wr_err), 32'h1);
    tick();
    chk("err_clr", 32'(wr_err), 32'h0);
    rd(16);
    tick();
    chk("oob_v", 32'(rd_valid), 32'h1);
    chk("oob_d", 32'(rd_data), 32'h0);
    for (int i = 0; i < 15; i++) wr(i, 16'h0000);
    pulse_fs();
    chk("f2_drop", 32'(drop), 32'h1);
    chk("f2_wb", 32'(wr_bank), 32'h1);
    chk("f2_rdy", 32'(ready), 32'h0);
    pulse_req();
    chk("f2_ack", 32'(ack), 32'h1);
    chk("f2_new", 32'(rnew), 32'h0);
    chk("f2_rb", 32'(rd_bank), 32'h0);

    // frame 3 (bank 1), then coincident start/request with pixel 0 write
    for (int i = 0; i < 16; i++)
      wr(i, (i == 7) ? 16'h07E0 : 16'h001F);
    fs = 1'b1;
    req = 1'b1;
    wr_en = 1'b1;
    wr_addr = 17'd0;
    wr_data = 16'hFFFF;
    tick();
    fs = 1'b0;
    req = 1'b0;
    wr_en = 1'b0;
    chk("co_rb", 32'(rd_bank), 32'h1);
    chk("co_wb", 32'(wr_bank), 32'h0);
    chk("co_ack", 32'(ack), 32'h1);
    chk("co_new", 32'(rnew), 32'h1);
    chk("co_rdy", 32'(ready), 32'h0);
    chk("co_drop", 32'(drop), 32'h1);
    rd_en = 1'b1;
    rd_addr = 17'd7;
    tick();
    rd_addr = 17'd2;
    tick();
    rd_en = 1'b0;
    chk("rd7_d", 32'(rd_data), 32'h00FF00);
    tick();
    chk("rd2_d", 32'(rd_data), 32'h0000FF);
    chk("rd2_v", 32'(rd_valid), 32'h1);

    // frame 4 (bank 0), pixel 0 already written with the start
    for (int i = 1; i < 16; i++) wr(i, 16'h0000);
    pulse_fs();
    chk("f4_wb", 32'(wr_bank), 32'h2);
    chk("f4_rdy", 32'(ready), 32'h1);
    chk("f4_drop", 32'(drop), 32'h1);
    pulse_req();
    chk("f4_rb", 32'(rd_bank), 32'h0);
    chk("f4_new", 32'(rnew), 32'h1);
    rd(0);
    tick();
    chk("rd0_d", 32'(rd_data), 32'hFFFFFF);

    // reset in the middle of a frame
    for (int i = 0; i < 5; i++) wr(i, 16'h0001);
    rst_n = 1'b0;
    #2;
    chk("mr_drop", 32'(drop), 32'h0);
    chk("mr_rdy", 32'(ready), 32'h0);
    chk("mr_wb", 32'(wr_bank), 32'h0);
    chk("mr_rb", 32'(rd_bank), 32'h2);
    chk("mr_rv", 32'(rd_valid), 32'h0);
    chk("mr_d", 32'(rd_data), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    wr(16, 16'h0);
    chk("idle_err", 32'(wr_err), 32'h0);
    for (int i = 0; i < 16; i++) wr(i, 16'hAAAA);
    pulse_fs();
    chk("idle_rdy", 32'(ready), 32'h0);
    chk("idle_drop", 32'(drop), 32'h0);
    rd(0);
    tick();
    chk("idle_rv", 32'(rd_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
